// File: rtl/trivium_stream_sink.sv
// Byte FIFO on the Trivium core output: buffers ciphertext, reports occupancy on fifo_cnd, drains via valid/ready.
// Optional TRIV_SINK_STAT_EN adds a 32-bit drain_cnt of accepted reads.
module trivium_stream_sink #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        stream,
    input  logic              wt_sgn,
    input  logic [7:0]        sign_reg,
    output logic [1:0]        fifo_cnd,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              ovf_flag
`ifdef TRIV_SINK_STAT_EN
    ,
    output logic [31:0]       drain_cnt
`endif
);

    typedef enum logic [2:0] {ST_EMPTY, ST_FILL, ST_DRAIN, ST_FULL, ST_OVF} state_t;

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [7:0]        hold;
    logic [ADDR_W:0]   level_nxt;
    state_t            state;
    state_t            state_nxt;
    logic              flush;
    logic              rd_acc;
    logic              wr_acc;
    logic              wr_drop;

    // Error or Total_RST from the core wipes the buffer and beats any same-cycle traffic.
    assign flush     = sign_reg[5] | sign_reg[6];
    assign out_valid = (level != '0);
    assign rd_acc    = out_valid && out_ready && !flush;
    assign wr_acc    = wt_sgn && !flush && ((level != LVL_FULL) || rd_acc);
    assign wr_drop   = wt_sgn && !flush && !wr_acc;
    assign out_data  = out_valid ? mem[rd_ptr] : hold;

    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[wr_ptr] <= stream;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf_flag <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_drop) ovf_flag <= 1'b1;
            level <= level_nxt;
        end
    end

    // Remember the last presented head so out_data holds once the FIFO runs dry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold <= 8'h00;
        end else if (out_valid) begin
            hold <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_cnd  = 2'b00;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else if (wr_drop) begin
            state_nxt = ST_OVF;
        end else begin
            case (state)
                ST_EMPTY: if (wr_acc) state_nxt = ST_FILL;
                ST_FILL: begin
                    if (level_nxt == LVL_FULL)   state_nxt = ST_FULL;
                    else if (level_nxt == '0)    state_nxt = ST_EMPTY;
                    else if (sign_reg[4])        state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (level_nxt == '0)          state_nxt = ST_EMPTY;
                    else if (level_nxt == LVL_FULL) state_nxt = ST_FULL;
                end
                ST_FULL:  if (rd_acc && !wr_acc) state_nxt = ST_DRAIN;
                ST_OVF:   state_nxt = ST_OVF;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
        case (state)
            ST_FILL, ST_DRAIN: fifo_cnd = 2'b01;
            ST_FULL:           fifo_cnd = 2'b10;
            ST_OVF:            fifo_cnd = 2'b11;
            default:           fifo_cnd = 2'b00;
        endcase
    end

`ifdef TRIV_SINK_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst || flush) drain_cnt <= 32'd0;
        else if (rd_acc)   drain_cnt <= drain_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_trivium_stream_sink.sv
// Directed bench for trivium_stream_sink with a byte scoreboard; define TRIV_SINK_STAT_EN to cover drain_cnt.
module tb_trivium_stream_sink;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic [7:0]        stream;
    logic              wt_sgn;
    logic [7:0]        sign_reg;
    logic [1:0]        fifo_cnd;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   level;
    logic              ovf_flag;
`ifdef TRIV_SINK_STAT_EN
    logic [31:0]       drain_cnt;
`endif

    int         checks   = 0;
    int         failures = 0;
    int         mlvl     = 0;
    int         mdrain   = 0;
    logic [7:0] sb [$];

    trivium_stream_sink #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (stream),
        .wt_sgn    (wt_sgn),
        .sign_reg  (sign_reg),
        .fifo_cnd  (fifo_cnd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf_flag  (ovf_flag)
`ifdef TRIV_SINK_STAT_EN
        ,
        .drain_cnt (drain_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, score any read against the queue, advance the model, step past the edge.
    task automatic cycle(input logic r, input logic w, input logic [7:0] d,
                         input logic rdy, input logic [7:0] sr);
        logic       rd;
        logic       wok;
        logic [7:0] e;
        rst = r; wt_sgn = w; stream = d; out_ready = rdy; sign_reg = sr;
        #1;
        if (!r || sr[5] || sr[6]) begin
            sb.delete();
            mlvl   = 0;
            mdrain = 0;
        end else begin
            rd  = (mlvl != 0) && rdy;
            wok = w && ((mlvl < DEPTH) || rd);
            if (rd) begin
                e = sb.pop_front();
                check("rd_data", 32'(out_data), 32'(e));
                mdrain++;
            end
            if (wok) sb.push_back(d);
            mlvl = mlvl + (wok ? 1 : 0) - (rd ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        cycle(1'b1, 1'b1, d, 1'b0, 8'h00);
    endtask

    task automatic rd_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    endtask

    initial begin
        rst = 1'b0; wt_sgn = 1'b0; stream = 8'h00; out_ready = 1'b0; sign_reg = 8'h00;

        // Reset state
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("rst_level", 32'(level), 32'd0);
        check("rst_cnd", 32'(fifo_cnd), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ovf", 32'(ovf_flag), 32'd0);

        // Three bytes then drain
        wr(8'hA5); wr(8'h3C); wr(8'hFF);
        check("t1_level", 32'(level), 32'd3);
        check("t1_cnd", 32'(fifo_cnd), 32'd1);
        check("t1_head", 32'(out_data), 32'hA5);
        rd_n(3);
        check("t1_level0", 32'(level), 32'd0);
        check("t1_cnd0", 32'(fifo_cnd), 32'd0);
        check("t1_valid0", 32'(out_valid), 32'd0);
        check("t1_hold", 32'(out_data), 32'hFF);

        // Fill to full, overflow, drain in OVF
        for (int i = 0; i < DEPTH; i++) wr(8'(i));
        check("t2_cnd_full", 32'(fifo_cnd), 32'd2);
        check("t2_level", 32'(level), 32'(DEPTH));
        check("t2_ovf0", 32'(ovf_flag), 32'd0);
        wr(8'h77);
        check("t2_ovf1", 32'(ovf_flag), 32'd1);
        check("t2_cnd_ovf", 32'(fifo_cnd), 32'd3);
        check("t2_level_ovf", 32'(level), 32'(DEPTH));
        rd_n(DEPTH);
        check("t2_level0", 32'(level), 32'd0);
        check("t2_cnd_sticky", 32'(fifo_cnd), 32'd3);
        check("t2_last", 32'(out_data), 32'hFF);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h20);
        check("t2_flush_cnd", 32'(fifo_cnd), 32'd0);
        check("t2_flush_ovf", 32'(ovf_flag), 32'd0);

        // Full with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) wr(8'(i) ^ 8'h5A);
        cycle(1'b1, 1'b1, 8'h11, 1'b1, 8'h00);
        check("t3_level", 32'(level), 32'(DEPTH));
        check("t3_ovf", 32'(ovf_flag), 32'd0);
        check("t3_cnd", 32'(fifo_cnd), 32'd2);
        rd_n(DEPTH - 1);
        check("t3_last_head", 32'(out_data), 32'h11);
        rd_n(1);
        check("t3_cnd0", 32'(fifo_cnd), 32'd0);

        // Secret_Ready moves to DRAIN
        for (int i = 0; i < 10; i++) wr(8'hC0 + 8'(i));
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h10);
        check("t4_cnd_drain", 32'(fifo_cnd), 32'd1);
        rd_n(9);
        check("t4_cnd_mid", 32'(fifo_cnd), 32'd1);
        rd_n(1);
        check("t4_cnd0", 32'(fifo_cnd), 32'd0);
        check("t4_level0", 32'(level), 32'd0);

        // Flush via Total_RST, then via Error, each with a colliding write
        for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
        cycle(1'b1, 1'b1, 8'h99, 1'b1, 8'h40);
        check("t5a_level", 32'(level), 32'd0);
        check("t5a_valid", 32'(out_valid), 32'd0);
        check("t5a_ovf", 32'(ovf_flag), 32'd0);
        check("t5a_cnd", 32'(fifo_cnd), 32'd0);
        for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
        cycle(1'b1, 1'b1, 8'h98, 1'b0, 8'h20);
        check("t5b_level", 32'(level), 32'd0);
        check("t5b_valid", 32'(out_valid), 32'd0);
        check("t5b_ovf", 32'(ovf_flag), 32'd0);
        check("t5b_cnd", 32'(fifo_cnd), 32'd0);
        wr(8'h42);
        check("t5_post_head", 32'(out_data), 32'h42);
        rd_n(1);

        // Reset mid-burst
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h20);
        for (int i = 0; i < 7; i++) wr(8'h70 + 8'(i));
        rd_n(4);
        check("t6_level", 32'(level), 32'd3);
`ifdef TRIV_SINK_STAT_EN
        check("t6_drain_cnt", drain_cnt, 32'(mdrain));
        check("t6_drain_cnt4", drain_cnt, 32'd4);
`endif
        cycle(1'b0, 1'b1, 8'hEE, 1'b0, 8'h00);
        check("t6_rst_level", 32'(level), 32'd0);
        check("t6_rst_cnd", 32'(fifo_cnd), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_ovf", 32'(ovf_flag), 32'd0);
`ifdef TRIV_SINK_STAT_EN
        check("t6_rst_drain", drain_cnt, 32'd0);
`endif
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("t6_after_level", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
